// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
//   Two-requester frame arbiter in front of an Ethernet TX MAC. A requester is
//   granted in IDLE. Its frame is then passed through byte by byte until the
//   byte carrying LAST is accepted. An inter-frame gap of IFG_CYCLES idle
//   cycles follows before the next arbitration.
//
//   Arbitration policy is selected at build time by the macro ETH_TX_ARB_RR_EN:
//     defined   : round-robin. When both ports request, the port not served
//                 last wins. The pointer starts at "port 1 served last".
//     undefined : strict priority. Port 0 wins whenever both request.
//
// Parameters
//   DATA_W      byte-lane width of every data port
//   IFG_CYCLES  idle cycles enforced between frames (0..255)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s0_data/valid/last/ready   requester 0 byte stream (ready is an output)
//   s1_data/valid/last/ready   requester 1 byte stream (ready is an output)
//   m_data/valid/last          byte stream toward the MAC
//   m_ready                    MAC accepts the current byte
//   grant                      one-hot current owner, 2'b00 when none
//   busy                       high while sending a frame or holding the gap
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
  parameter int DATA_W     = 8,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_valid,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_valid,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [1:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SEND, IFG} state_t;

  localparam logic [7:0] IFG_LD = 8'(IFG_CYCLES);

  state_t     state, state_nxt;
  logic [1:0] grant_nxt;
  logic [7:0] gap_cnt, gap_nxt;
  logic [1:0] pick;
  logic       xfer_last;

`ifdef ETH_TX_ARB_RR_EN
  // 1 means port 1 was served last, so port 0 wins the next contention.
  logic last_srv, last_srv_nxt;
`endif

  // Frame ends on the accepted byte that carries LAST.
  assign xfer_last = m_valid & m_ready & m_last;
  assign busy      = (state != IDLE);

  // Winner among the current requesters (one-hot, 2'b00 if nobody requests).
  always_comb begin
    pick = 2'b00;
`ifdef ETH_TX_ARB_RR_EN
    if (s0_valid && s1_valid) pick = last_srv ? 2'b01 : 2'b10;
    else if (s0_valid)        pick = 2'b01;
    else if (s1_valid)        pick = 2'b10;
`else
    if (s0_valid)      pick = 2'b01;
    else if (s1_valid) pick = 2'b10;
`endif
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    gap_nxt   = gap_cnt;
`ifdef ETH_TX_ARB_RR_EN
    last_srv_nxt = last_srv;
`endif
    case (state)
      IDLE: begin
        if (pick != 2'b00) begin
          grant_nxt = pick;
          state_nxt = SEND;
`ifdef ETH_TX_ARB_RR_EN
          last_srv_nxt = pick[1];
`endif
        end
      end
      SEND: begin
        if (xfer_last) begin
          grant_nxt = 2'b00;
          if (IFG_CYCLES > 0) begin
            state_nxt = IFG;
            gap_nxt   = IFG_LD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      IFG: begin
        // Counter runs IFG_CYCLES..1, one IFG cycle per value.
        if (gap_cnt <= 8'd1) begin
          state_nxt = IDLE;
          gap_nxt   = 8'd0;
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
        gap_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= 2'b00;
      gap_cnt <= 8'd0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      gap_cnt <= gap_nxt;
    end
  end

`ifdef ETH_TX_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_srv <= 1'b1;
    else        last_srv <= last_srv_nxt;
  end
`endif

  // Combinational pass-through of the owner while sending; all zero otherwise.
  always_comb begin
    m_data   = '0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    if (state == SEND) begin
      if (grant[0]) begin
        m_data   = s0_data;
        m_valid  = s0_valid;
        m_last   = s0_last;
        s0_ready = m_ready;
      end else if (grant[1]) begin
        m_data   = s1_data;
        m_valid  = s1_valid;
        m_last   = s1_last;
        s1_ready = m_ready;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_arbiter
//   Directed bench for eth_tx_arbiter. A frame-level model (owner / remaining
//   gap) predicts every output on every cycle; literal checks pin byte order,
//   latency, gap length and grant order for each scenario. A second instance
//   with IFG_CYCLES=0 covers back-to-back frames.
// -----------------------------------------------------------------------------
module tb_eth_tx_arbiter;
  localparam int DW  = 8;
  localparam int IFG = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic          s0_valid, s0_last, s0_ready, s1_valid, s1_last, s1_ready;
  logic          m_valid, m_last, m_ready, busy;
  logic [1:0]    grant;

  logic [DW-1:0] z_s0_data, z_s1_data, z_m_data;
  logic          z_s0_valid, z_s0_last, z_s0_ready, z_s1_valid, z_s1_last, z_s1_ready;
  logic          z_m_valid, z_m_last, z_m_ready, z_busy;
  logic [1:0]    z_grant;

  eth_tx_arbiter #(.DATA_W(DW), .IFG_CYCLES(IFG)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .grant(grant), .busy(busy));

  eth_tx_arbiter #(.DATA_W(DW), .IFG_CYCLES(0)) u_dut_z (
    .clk(clk), .rst_n(rst_n),
    .s0_data(z_s0_data), .s0_valid(z_s0_valid), .s0_last(z_s0_last), .s0_ready(z_s0_ready),
    .s1_data(z_s1_data), .s1_valid(z_s1_valid), .s1_last(z_s1_last), .s1_ready(z_s1_ready),
    .m_data(z_m_data), .m_valid(z_m_valid), .m_last(z_m_last), .m_ready(z_m_ready),
    .grant(z_grant), .busy(z_busy));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  logic abort = 1'b0;

  // Observed traffic, appended by the compare process, read by the scenarios.
  logic [7:0] acc_d[$];
  logic       acc_l[$];
  int         acc_c[$];
  int         grant_q[$];
  int         gap_q[$];
  int         s1_send = 0;

`ifdef ETH_TX_ARB_RR_EN
  int exp_ord[4] = '{0, 1, 0, 1};
`else
  int exp_ord[4] = '{0, 0, 1, 1};
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Frame-level reference model and per-cycle compare.
  initial begin : model
    int owner, gap, last_srv, pick, run, gprev;
    logic [7:0] ed;
    logic ev, el, r0, r1, eb;
    logic [1:0] eg;
    owner = -1; gap = 0; last_srv = 1; run = 0; gprev = 0;
    forever begin
      @(negedge clk);
      ed = 0; ev = 0; el = 0; r0 = 0; r1 = 0; eg = 0; eb = 0;
      if (!rst_n) begin
        owner = -1; gap = 0; last_srv = 1; run = 0; gprev = 0;
      end else begin
        if (owner == 0) begin ed = s0_data; ev = s0_valid; el = s0_last; r0 = m_ready; eg = 2'b01; end
        if (owner == 1) begin ed = s1_data; ev = s1_valid; el = s1_last; r1 = m_ready; eg = 2'b10; end
        eb = (owner >= 0) || (gap > 0);
      end
      chk("m_data", m_data, ed);
      chk("m_valid", m_valid, ev);
      chk("m_last", m_last, el);
      chk("s0_ready", s0_ready, r0);
      chk("s1_ready", s1_ready, r1);
      chk("grant", grant, eg);
      chk("busy", busy, eb);
      if (rst_n) begin
        if (m_valid && m_ready) begin
          acc_d.push_back(m_data); acc_l.push_back(m_last); acc_c.push_back(cyc);
        end
        if (grant != 2'b00 && gprev == 0) grant_q.push_back(grant == 2'b01 ? 0 : 1);
        gprev = (grant != 2'b00) ? 1 : 0;
        if (grant == 2'b10) s1_send++;
        if (busy && grant == 2'b00) run++;
        else if (run > 0) begin gap_q.push_back(run); run = 0; end
        // advance one cycle
        if (owner >= 0) begin
          if (ev && m_ready && el) begin owner = -1; gap = IFG; end
        end else if (gap > 0) begin
          gap--;
        end else if (s0_valid || s1_valid) begin
`ifdef ETH_TX_ARB_RR_EN
          if (s0_valid && s1_valid) pick = 1 - last_srv;
          else                      pick = s0_valid ? 0 : 1;
`else
          pick = s0_valid ? 0 : 1;
`endif
          owner = pick; last_srv = pick;
        end
      end
    end
  end

  task automatic drive(input int p, input logic [7:0] d, input logic v, input logic l);
    if (p == 0) begin s0_data = d; s0_valid = v; s0_last = l; end
    else        begin s1_data = d; s1_valid = v; s1_last = l; end
  endtask

  // Send n bytes first, first+step, ... from port p; optional 2-cycle VALID hole
  // before byte index hole. Called at posedge+1, returns at posedge+1.
  task automatic send(input int p, input int n, input logic [7:0] first,
                      input logic [7:0] step, input int hole);
    logic got;
    int t;
    for (int i = 0; i < n; i++) begin
      if (i == hole) begin
        drive(p, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
      end
      drive(p, first + 8'(i) * step, 1'b1, (i == n - 1));
      got = 1'b0;
      t = 0;
      while (!got && t < 300) begin
        @(negedge clk);
        if (abort) begin drive(p, 8'h00, 1'b0, 1'b0); return; end
        got = (p == 0) ? s0_ready : s1_ready;
        @(posedge clk);
        #1;
        t++;
      end
      chk($sformatf("handshake_p%0d_b%0d", p, i), got, 1'b1);
    end
    drive(p, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic settle();
    repeat (16) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int b, gb, pb, sb, t0, t;
    logic got;
    int zc[$];
    rst_n = 1'b0; m_ready = 1'b1;
    drive(0, 8'h00, 1'b0, 1'b0); drive(1, 8'h00, 1'b0, 1'b0);
    z_s0_data = 0; z_s0_valid = 0; z_s0_last = 0;
    z_s1_data = 0; z_s1_valid = 0; z_s1_last = 0; z_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 2'b00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame, full throughput.
    b = acc_d.size(); gb = grant_q.size(); pb = gap_q.size(); t0 = cyc;
    send(0, 4, 8'h11, 8'h11, -1);
    settle();
    chk("t1_count", acc_d.size() - b, 4);
    for (int i = 0; i < 4 && b + i < acc_d.size(); i++) begin
      chk($sformatf("t1_byte%0d", i), acc_d[b+i], 8'h11 * (i + 1));
      chk($sformatf("t1_last%0d", i), acc_l[b+i], (i == 3));
    end
    if (acc_c.size() >= b + 4) begin
      chk("t1_latency", acc_c[b] - t0, 1);
      chk("t1_contig", acc_c[b+3] - acc_c[b], 3);
    end
    chk("t1_owner", (grant_q.size() > gb) ? grant_q[gb] : -1, 0);
    chk("t1_gap", (gap_q.size() > pb) ? gap_q[pb] : -1, 12);

    // Late request from port 1 while port 0 sends (with a VALID hole).
    b = acc_d.size(); gb = grant_q.size(); pb = gap_q.size();
    fork
      send(0, 3, 8'h31, 8'h01, 1);
      begin
        repeat (2) @(posedge clk);
        #1;
        send(1, 2, 8'h41, 8'h01, -1);
      end
    join
    settle();
    chk("t4_count", acc_d.size() - b, 5);
    if (acc_d.size() >= b + 5) begin
      chk("t4_b0", acc_d[b], 8'h31);   chk("t4_b2", acc_d[b+2], 8'h33);
      chk("t4_b3", acc_d[b+3], 8'h41); chk("t4_b4", acc_d[b+4], 8'h42);
      chk("t4_holdoff", acc_c[b+3] - acc_c[b+2], IFG + 2);
    end
    chk("t4_order0", (grant_q.size() > gb) ? grant_q[gb] : -1, 0);
    chk("t4_order1", (grant_q.size() > gb + 1) ? grant_q[gb+1] : -1, 1);
    chk("t4_gap", (gap_q.size() > pb) ? gap_q[pb] : -1, 12);

    // Contention: both ports hold two 3-byte frames each.
    b = acc_d.size(); gb = grant_q.size();
    fork
      begin send(0, 3, 8'h01, 8'h01, -1); send(0, 3, 8'h04, 8'h01, -1); end
      begin send(1, 3, 8'h81, 8'h01, -1); send(1, 3, 8'h84, 8'h01, -1); end
    join
    settle();
    chk("t2_count", acc_d.size() - b, 12);
    chk("t2_grants", grant_q.size() - gb, 4);
    for (int i = 0; i < 4 && gb + i < grant_q.size(); i++)
      chk($sformatf("t2_order%0d", i), grant_q[gb+i], exp_ord[i]);

    // Backpressure: M_READY alternates during a port-1 frame.
    b = acc_d.size(); sb = s1_send;
    fork
      send(1, 4, 8'hA1, 8'h01, -1);
      begin
        repeat (10) begin
          @(posedge clk);
          #1;
          m_ready = ~m_ready;
        end
        m_ready = 1'b1;
      end
    join
    settle();
    chk("t3_send_cycles", s1_send - sb, 8);
    chk("t3_count", acc_d.size() - b, 4);
    for (int i = 0; i < 4 && b + i < acc_d.size(); i++)
      chk($sformatf("t3_byte%0d", i), acc_d[b+i], 8'hA1 + i);

    // Reset in the middle of a 5-byte frame.
    b = acc_d.size();
    fork
      send(0, 5, 8'h61, 8'h01, -1);
      begin
        t = 0;
        while (acc_d.size() < b + 2 && t < 100) begin
          @(posedge clk);
          t++;
        end
        chk("t5_reached_byte2", (t < 100), 1'b1);
        #1;
        rst_n = 1'b0; abort = 1'b1;
        #1;
        chk("t5_m_valid", m_valid, 1'b0); chk("t5_m_last", m_last, 1'b0);
        chk("t5_m_data", m_data, 8'h00);  chk("t5_s0_ready", s0_ready, 1'b0);
        chk("t5_s1_ready", s1_ready, 1'b0); chk("t5_grant", grant, 2'b00);
        chk("t5_busy", busy, 1'b0);
      end
    join
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; abort = 1'b0;
    chk("t5_aborted_count", acc_d.size() - b, 2);
    if (acc_l.size() >= b + 2) chk("t5_no_last", acc_l[b] | acc_l[b+1], 1'b0);
    @(posedge clk);
    #1;
    b = acc_d.size(); t0 = cyc;
    send(0, 3, 8'h71, 8'h01, -1);
    settle();
    chk("t5_new_count", acc_d.size() - b, 3);
    if (acc_d.size() >= b + 3) begin
      chk("t5_new_b0", acc_d[b], 8'h71); chk("t5_new_b2", acc_d[b+2], 8'h73);
      chk("t5_new_last", acc_l[b+2], 1'b1);
      chk("t5_new_latency", acc_c[b] - t0, 1);
    end

    // Zero inter-frame gap: two back-to-back 3-byte frames on port 0.
    for (int i = 0; i < 6; i++) begin
      z_s0_data = 8'(i + 1); z_s0_valid = 1'b1; z_s0_last = (i == 2 || i == 5);
      got = 1'b0; t = 0;
      while (!got && t < 50) begin
        @(negedge clk);
        if (i == 3 && t == 0) begin
          chk("t6_idle_busy", z_busy, 1'b0);
          chk("t6_idle_valid", z_m_valid, 1'b0);
        end
        got = z_s0_ready;
        if (got) chk($sformatf("t6_data%0d", i), z_m_data, 8'(i + 1));
        if (got) zc.push_back(cyc);
        @(posedge clk);
        #1;
        t++;
      end
      chk($sformatf("t6_handshake%0d", i), got, 1'b1);
    end
    z_s0_valid = 1'b0; z_s0_last = 1'b0;
    if (zc.size() == 6) begin
      chk("t6_contig", zc[2] - zc[0], 2);
      chk("t6_one_gap", zc[3] - zc[2], 2);
      chk("t6_contig2", zc[5] - zc[3], 2);
    end
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
